// File: rtl/vga_timing_pkg.sv
// Shared constants, phase encoding and boundary helper for the VGA raster timing block.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int H_ACTIVE_D = 640;
    localparam int H_FP_D     = 16;
    localparam int H_SYNC_D   = 96;
    localparam int H_BP_D     = 48;
    localparam int V_ACTIVE_D = 480;
    localparam int V_FP_D     = 10;
    localparam int V_SYNC_D   = 2;
    localparam int V_BP_D     = 33;

    localparam int H_TOTAL_D = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    // Last counter index belonging to the given phase.
    function automatic int phase_last(input int active, input int fp,
                                      input int sync, input int bp,
                                      input phase_t ph);
        int last;
        last = active + fp + sync + bp - 1;
        case (ph)
            PH_ACTIVE: last = active - 1;
            PH_FRONT:  last = active + fp - 1;
            PH_SYNC:   last = active + fp + sync - 1;
            default:   last = active + fp + sync + bp - 1;
        endcase
        return last;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = H_ACTIVE_D,
    parameter int FP     = H_FP_D,
    parameter int SYNC   = H_SYNC_D,
    parameter int BP     = H_BP_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    output logic [CNT_W-1:0] count,
    output phase_t           phase_next,
    output logic             wrap,
    output logic             sync
);

    localparam logic [CNT_W-1:0] LAST_A =
        CNT_W'(phase_last(ACTIVE, FP, SYNC, BP, PH_ACTIVE));
    localparam logic [CNT_W-1:0] LAST_F =
        CNT_W'(phase_last(ACTIVE, FP, SYNC, BP, PH_FRONT));
    localparam logic [CNT_W-1:0] LAST_S =
        CNT_W'(phase_last(ACTIVE, FP, SYNC, BP, PH_SYNC));
    localparam logic [CNT_W-1:0] LAST_B =
        CNT_W'(phase_last(ACTIVE, FP, SYNC, BP, PH_BACK));

    phase_t           phase;
    logic [CNT_W-1:0] count_next;

    assign wrap = (count == LAST_B);
    assign sync = (phase == PH_SYNC);

    // Reset parks the axis on its final index so the first advance wraps to 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= LAST_B;
            phase <= PH_BACK;
        end else begin
            count <= count_next;
            phase <= phase_next;
        end
    end

    always_comb begin
        count_next = count;
        phase_next = phase;
        if (advance) begin
            count_next = wrap ? '0 : count + CNT_W'(1);
            unique case (phase)
                PH_ACTIVE: if (count == LAST_A) phase_next = PH_FRONT;
                PH_FRONT:  if (count == LAST_F) phase_next = PH_SYNC;
                PH_SYNC:   if (count == LAST_S) phase_next = PH_BACK;
                PH_BACK:   if (count == LAST_B) phase_next = PH_ACTIVE;
                default:   phase_next = PH_BACK;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, registered qualifiers and delayed sync pulses.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_D,
    parameter int H_FP       = H_FP_D,
    parameter int H_SYNC     = H_SYNC_D,
    parameter int H_BP       = H_BP_D,
    parameter int V_ACTIVE   = V_ACTIVE_D,
    parameter int V_FP       = V_FP_D,
    parameter int V_SYNC     = V_SYNC_D,
    parameter int V_BP       = V_BP_D,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SYNC_DELAY = 1
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic             enable,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count,
    output logic             active_pixel,
    output logic             line_start,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync
);

    localparam bit IDLE = ~SYNC_POL;

    phase_t h_phase_next;
    phase_t v_phase_next;
    logic   h_wrap;
    logic   v_wrap;
    logic   h_sync_raw;
    logic   v_sync_raw;
    logic   h_level;
    logic   v_level;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk        (clk_25),
        .rst_n      (rst_n),
        .advance    (enable),
        .count      (x_count),
        .phase_next (h_phase_next),
        .wrap       (h_wrap),
        .sync       (h_sync_raw)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk        (clk_25),
        .rst_n      (rst_n),
        .advance    (enable & h_wrap),
        .count      (y_count),
        .phase_next (v_phase_next),
        .wrap       (v_wrap),
        .sync       (v_sync_raw)
    );

    // Flags decode the position being entered, so they line up with the new counts.
    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            active_pixel <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else if (enable) begin
            active_pixel <= (h_phase_next == PH_ACTIVE) &&
                            (v_phase_next == PH_ACTIVE);
            line_start   <= h_wrap;
            frame_start  <= h_wrap && v_wrap;
        end
    end

    assign h_level = h_sync_raw ? SYNC_POL : IDLE;
    assign v_level = v_sync_raw ? SYNC_POL : IDLE;

    if (SYNC_DELAY == 0) begin : g_nodly
        assign hsync = h_level;
        assign vsync = v_level;
    end else begin : g_dly
        logic [SYNC_DELAY-1:0] h_sr;
        logic [SYNC_DELAY-1:0] v_sr;

        always_ff @(posedge clk_25) begin
            if (!rst_n) begin
                h_sr <= {SYNC_DELAY{IDLE}};
                v_sr <= {SYNC_DELAY{IDLE}};
            end else if (enable) begin
                h_sr <= (h_sr << 1) | SYNC_DELAY'(h_level);
                v_sr <= (v_sr << 1) | SYNC_DELAY'(v_level);
            end
        end

        assign hsync = h_sr[SYNC_DELAY-1];
        assign vsync = v_sr[SYNC_DELAY-1];
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default raster, zero-delay sync variant and a tiny raster for full frames.
module tb_vga_timing_gen;

    logic clk_25 = 1'b0;
    always #20 clk_25 = ~clk_25;

    logic       rst_n;
    logic       enable;
    logic       rst_s;
    logic       en_s;
    logic [9:0] x_a, y_a, x_b, y_b, x_s, y_s;
    logic       act_a, ls_a, fs_a, hs_a, vs_a;
    logic       act_b, ls_b, fs_b, hs_b, vs_b;
    logic       act_s, ls_s, fs_s, hs_s, vs_s;

    int checks = 0;
    int errors = 0;

    int bad, act_n, act_last, hs_n, hs_first, hs_last;
    int hb_n, hb_first, hb_last;
    int fs_n, fs_pos, ls_n, vs_n, vs_first;

    vga_timing_gen u_a (
        .clk_25(clk_25), .rst_n(rst_n), .enable(enable),
        .x_count(x_a), .y_count(y_a), .active_pixel(act_a),
        .line_start(ls_a), .frame_start(fs_a),
        .hsync(hs_a), .vsync(vs_a)
    );

    vga_timing_gen #(.SYNC_DELAY(0)) u_b (
        .clk_25(clk_25), .rst_n(rst_n), .enable(enable),
        .x_count(x_b), .y_count(y_b), .active_pixel(act_b),
        .line_start(ls_b), .frame_start(fs_b),
        .hsync(hs_b), .vsync(vs_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3)
    ) u_s (
        .clk_25(clk_25), .rst_n(rst_s), .enable(en_s),
        .x_count(x_s), .y_count(y_s), .active_pixel(act_s),
        .line_start(ls_s), .frame_start(fs_s),
        .hsync(hs_s), .vsync(vs_s)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_25);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        rst_s  = 1'b0;
        en_s   = 1'b1;
        repeat (3) tick();

        check("rst_x", x_a, 799);
        check("rst_y", y_a, 524);
        check("rst_act", act_a, 0);
        check("rst_ls", ls_a, 0);
        check("rst_fs", fs_a, 0);
        check("rst_hs", hs_a, 1);
        check("rst_vs", vs_a, 1);
        check("rst_hs_d0", hs_b, 1);

        rst_n = 1'b1;
        tick();
        check("first_x", x_a, 0);
        check("first_y", y_a, 0);
        check("first_act", act_a, 1);
        check("first_ls", ls_a, 1);
        check("first_fs", fs_a, 1);

        bad = 0; act_n = 0; act_last = -1;
        hs_n = 0; hs_first = -1; hs_last = -1;
        hb_n = 0; hb_first = -1; hb_last = -1;
        for (int i = 0; i < 800; i++) begin
            if (x_a !== 10'(i) || y_a !== 10'd0 || x_b !== x_a) bad++;
            if (act_a) begin
                act_n++;
                act_last = int'(x_a);
            end
            if (!hs_a) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(x_a);
                hs_last = int'(x_a);
            end
            if (!hs_b) begin
                hb_n++;
                if (hb_first < 0) hb_first = int'(x_b);
                hb_last = int'(x_b);
            end
            tick();
        end
        check("line0_seq", bad, 0);
        check("line0_act_n", act_n, 640);
        check("line0_act_last", act_last, 639);
        check("line0_hs_n", hs_n, 96);
        check("line0_hs_first", hs_first, 657);
        check("line0_hs_last", hs_last, 752);
        check("line0_hs0_n", hb_n, 96);
        check("line0_hs0_first", hb_first, 656);
        check("line0_hs0_last", hb_last, 751);
        check("wrap_x", x_a, 0);
        check("wrap_y", y_a, 1);
        check("wrap_ls", ls_a, 1);
        check("wrap_fs", fs_a, 0);
        tick();
        check("wrap_ls_drop", ls_a, 0);
        check("wrap_x1", x_a, 1);

        repeat (654) tick();
        check("frz_pre_x", x_a, 655);
        enable = 1'b0;
        repeat (5) tick();
        check("frz_x", x_a, 655);
        check("frz_y", y_a, 1);
        check("frz_hs", hs_a, 1);
        check("frz_hs0", hs_b, 1);
        check("frz_ls", ls_a, 0);
        enable = 1'b1;
        tick();
        check("res_x656", x_a, 656);
        check("res_hs_656", hs_a, 1);
        check("res_hs0_656", hs_b, 0);
        tick();
        check("res_x657", x_a, 657);
        check("res_hs_657", hs_a, 0);

        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        check("mid_rst_x", x_a, 799);
        check("mid_rst_y", y_a, 524);
        check("mid_rst_act", act_a, 0);
        check("mid_rst_ls", ls_a, 0);
        check("mid_rst_fs", fs_a, 0);
        check("mid_rst_hs", hs_a, 1);
        check("mid_rst_vs", vs_a, 1);
        check("mid_rst_vs0", vs_b, 1);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick();
        check("mid_rel_x", x_a, 0);
        check("mid_rel_y", y_a, 0);
        check("mid_rel_fs", fs_a, 1);
        check("mid_rel_ls", ls_a, 1);
        check("mid_rel_act", act_a, 1);

        rst_s = 1'b1;
        tick();
        fs_n = 0; fs_pos = -1; ls_n = 0; act_n = 0;
        vs_n = 0; vs_first = -1; hs_n = 0;
        for (int i = 0; i < 192; i++) begin
            if (fs_s) begin
                fs_n++;
                fs_pos = int'(y_s) * 16 + int'(x_s);
            end
            if (ls_s) ls_n++;
            if (act_s) act_n++;
            if (!hs_s) hs_n++;
            if (!vs_s) begin
                vs_n++;
                if (vs_first < 0) vs_first = int'(y_s) * 16 + int'(x_s);
            end
            tick();
        end
        check("frame_fs_n", fs_n, 1);
        check("frame_fs_pos", fs_pos, 0);
        check("frame_ls_n", ls_n, 12);
        check("frame_act_n", act_n, 48);
        check("frame_hs_n", hs_n, 36);
        check("frame_vs_n", vs_n, 32);
        check("frame_vs_first", vs_first, 113);
        check("frame_end_x", x_s, 0);
        check("frame_end_y", y_s, 0);
        check("frame_end_fs", fs_s, 1);

        en_s = 1'b0;
        repeat (3) tick();
        check("frz0_x", x_s, 0);
        check("frz0_ls", ls_s, 1);
        check("frz0_fs", fs_s, 1);
        en_s = 1'b1;
        tick();
        check("frz0_res_x", x_s, 1);
        check("frz0_res_ls", ls_s, 0);
        check("frz0_res_fs", fs_s, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the 640x480@60 Hz VGA raster timing on the 25 MHz pixel clock: horizontal/vertical pixel counters, the `active_pixel` qualifier, and the `hsync`/`vsync` pulses. It is the producing end of the `x_count`/`y_count`/`active_pixel` interface consumed by the pixel-colour stage. It delays the sync pulses so that they leave the chip aligned with that stage's registered RGB output.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16 / `H_SYNC`, 96 / `H_BP`, 48: horizontal front porch, sync, and back porch, in pixels
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10 / `V_SYNC`, 2 / `V_BP`, 33: vertical front porch, sync, and back porch, in lines
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync` (0 = active-low)
- `SYNC_DELAY`, 1: pipeline stages on `hsync`/`vsync` (0..4)
- `clk_25` in 1: pixel clock, rising edge only
- `rst_n` in 1: reset; one clock; reset is synchronous and active-low
- `enable` in 1: advance the raster when high; freeze all state when low
- `x_count` out 10: current pixel column, 0..H_TOTAL-1
- `y_count` out 10: current line, 0..V_TOTAL-1
- `active_pixel` out 1: high while x < H_ACTIVE and y < V_ACTIVE
- `line_start` out 1: one-cycle pulse when x_count == 0
- `frame_start` out 1: one-cycle pulse when x_count == 0 and y_count == 0
- `hsync` out 1: horizontal sync, delayed by SYNC_DELAY cycles
- `vsync` out 1: vertical sync, delayed by SYNC_DELAY cycles

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤ 1024.
- Each axis runs a phase FSM with states ACTIVE → FRONT → SYNC → BACK → ACTIVE. A transition occurs when the axis counter reaches the last index of the current phase.
  - Horizontal boundaries: 639/655/751/799.
  - Vertical boundaries: 479/489/491/524.
- Horizontal counter:
  - increments by 1 on every enabled cycle;
  - at H_TOTAL-1 it wraps to 0.
- Vertical counter:
  - increments only on the horizontal wrap;
  - at V_TOTAL-1 (coinciding with the horizontal wrap) it wraps to 0.
- Raw sync is asserted (level SYNC_POL) when the phase is SYNC:
  - hsync for x in 656..751, on every line;
  - vsync for every pixel of lines 490..491.
- Registered outputs:
  - All registered outputs update together on the same edge and are mutually coherent.
  - `active_pixel`, `line_start`, and `frame_start` are registered decodes of the counter values they accompany, not of the previous values.
- Sync delay:
  - `hsync`/`vsync` pass through a SYNC_DELAY-deep shift register.
  - With SYNC_DELAY = 0 they are coherent with `x_count`.
- Freeze:
  - `enable` low holds counters, FSMs, pulses, and the sync shift register unchanged.
  - Pulses are not re-issued on resume; they keep their held value for the frozen cycles.
- Reset:
  - Reset loads the raster to its last position: x = H_TOTAL-1 (799), y = V_TOTAL-1 (524), both FSMs in BACK.
  - Reset values of all outputs: `x_count` = 799, `y_count` = 524, `active_pixel` = 0, `line_start` = 0, `frame_start` = 0. `hsync`, `vsync`, and every shift-register stage are at the deasserted level (!SYNC_POL).
  - Reset mid-frame takes effect at the next edge regardless of `enable`, and overrides everything.

## Timing
- First enabled edge after reset release: x = 0, y = 0, `active_pixel` = 1, `line_start` = 1, `frame_start` = 1.
- Raw hsync asserts on the edge that makes x = 656. The `hsync` output follows SYNC_DELAY cycles later; the default shows it first when x_count = 657.
- Horizontal wrap edge: x goes 799 → 0, y increments, and `line_start` = 1 for exactly one enabled cycle.
- End of frame (799, 524) → (0, 0): `frame_start` and `line_start` both pulse.
- `active_pixel` falls on the edge to x = 640 and rises on the edge to x = 0, for lines 0..479 only.

## Structure
- `vga_timing_pkg` holds:
  - the 640x480 default constants;
  - derived totals and boundary indices;
  - the phase enum (ACTIVE, FRONT, SYNC, BACK, 2 bits).
- Sub-module `vga_axis_counter` is instantiated twice. It takes parameters ACTIVE/FP/SYNC/BP and inputs `advance` and `rst_n`, and provides outputs for count, phase, wrap, and raw sync.
  - Horizontal instance: `advance` = `enable`.
  - Vertical instance: `advance` = `enable` & horizontal wrap.

## Test plan
- Reset check: hold `rst_n` low for 3 cycles, then release with `enable` = 1.
  - While in reset: x = 799, y = 524, `active_pixel` = 0, `hsync` = `vsync` = 1.
  - First edge after release: (0, 0), `frame_start` = `line_start` = 1.
- Line 0 sync: step through line 0.
  - `active_pixel` = 1 for x = 0..639.
  - `hsync` = 0 exactly while x_count = 657..752 (96 cycles).
  - Wrap 799 → 0 with y = 1 and a one-cycle `line_start`.
- Full frame: run 420000 cycles.
  - `frame_start` pulses exactly once, at (0, 0).
  - `vsync` = 0 for 1600 cycles, across lines 490–491 shifted by one pixel.
  - `active_pixel` count = 307200.
- Freeze: drop `enable` for 5 cycles at x = 655.
  - Counters, `hsync`, and `line_start` hold their values.
  - On resume, x goes 656 → 657 and `hsync` asserts one cycle later.
- Mid-frame reset: pulse `rst_n` low at (300, 200).
  - All outputs return to their reset values on that edge.
  - Release gives (0, 0) with a `frame_start` pulse.
- SYNC_DELAY = 0 variant: `hsync` is asserted exactly when x_count = 656..751.
